// File: rtl/conv_enc_pkg.sv
// Shared types and constants for the convolutional-encoder sequencing controller.
// The size flag picks the code-block byte count that is drained from the encoder.
package conv_enc_pkg;

  localparam int unsigned SMALL_BYTES = 132;
  localparam int unsigned LARGE_BYTES = 768;
  localparam int unsigned TIMEOUT_CYC = 2048;
  localparam int unsigned CNT_W       = 12;

  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    FETCH     = 4'd1,
    LOAD      = 4'd2,
    WAIT_DATA = 4'd3,
    START     = 4'd4,
    ENCODE    = 4'd5,
    DRAIN     = 4'd6,
    DONE      = 4'd7,
    ERR       = 4'd8
  } state_t;

  function automatic logic [CNT_W-1:0] size_to_bytes(input logic size);
    logic [CNT_W-1:0] n;
    if (size) begin
      n = CNT_W'(LARGE_BYTES);
    end else begin
      n = CNT_W'(SMALL_BYTES);
    end
    return n;
  endfunction

endpackage

// File: rtl/conv_enc_drain_cnt.sv
// Sub-block drain counters: gates encoder reads with downstream ready, tracks
// issued and returned triples, and flags the final returned triple of the block.
module conv_enc_drain_cnt
  import conv_enc_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             active,
  input  logic             ds_ready,
  input  logic [CNT_W-1:0] target,
  output logic             rdreq,
  output logic             out_valid,
  output logic             out_last
);

  logic [CNT_W-1:0] iss_cnt_r;
  logic [CNT_W-1:0] ret_cnt_r;
  logic             valid_r;

  // Read request drops in the same cycle ds_ready drops; one triple may still be in flight.
  assign rdreq     = active && ds_ready && (iss_cnt_r < target);
  assign out_valid = valid_r;
  assign out_last  = valid_r && (ret_cnt_r == (target - CNT_W'(1)));

  // Issued/returned counters and the one-cycle encoder read-latency stage
  always_ff @(posedge clk) begin
    if (reset) begin
      iss_cnt_r <= '0;
      ret_cnt_r <= '0;
      valid_r   <= 1'b0;
    end else if (clr) begin
      iss_cnt_r <= '0;
      ret_cnt_r <= '0;
      valid_r   <= 1'b0;
    end else begin
      valid_r <= rdreq;
      if (rdreq) begin
        iss_cnt_r <= iss_cnt_r + CNT_W'(1);
      end
      if (valid_r) begin
        ret_cnt_r <= ret_cnt_r + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/conv_enc_ctrl.sv
// Sequencing controller for the tail-biting convolutional encoder: fetches block
// metadata, starts the encoder, drains q0/q1/q2 and guards the encode phase with a watchdog.
module conv_enc_ctrl
  import conv_enc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        meta_empty,
  input  logic        meta_size,
  input  logic [7:0]  meta_tail,
  output logic        meta_rdreq,
  input  logic        blk_empty,
  output logic        enc_blk_ready,
  output logic [7:0]  enc_tail_byte,
  output logic        enc_size,
  input  logic        enc_done,
  output logic        enc_rdreq_subblock,
  input  logic        ds_ready,
  output logic        out_valid,
  output logic        out_last,
  output logic        out_size,
  output logic        busy,
  output logic        err_timeout,
  output logic [15:0] blk_count
);

  state_t           state_r;
  state_t           state_nx_s;
  logic [CNT_W-1:0] wdog_r;
  logic [CNT_W-1:0] target_r;
  logic [7:0]       tail_r;
  logic             size_r;
  logic             meta_rdreq_r;
  logic             blk_ready_r;
  logic             busy_r;
  logic             err_r;
  logic [15:0]      blk_cnt_r;
  logic             last_s;

  conv_enc_drain_cnt u_drain (
    .clk       (clk),
    .reset     (reset),
    .clr       (state_r == LOAD),
    .active    (state_r == DRAIN),
    .ds_ready  (ds_ready),
    .target    (target_r),
    .rdreq     (enc_rdreq_subblock),
    .out_valid (out_valid),
    .out_last  (last_s)
  );

  assign out_last      = last_s;
  assign meta_rdreq    = meta_rdreq_r;
  assign enc_blk_ready = blk_ready_r;
  assign enc_tail_byte = tail_r;
  assign enc_size      = size_r;
  assign out_size      = size_r;
  assign busy          = busy_r;
  assign err_timeout   = err_r;
  assign blk_count     = blk_cnt_r;

  // Next-state decode for the block sequencing FSM
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (!meta_empty) state_nx_s = FETCH;
        else             state_nx_s = IDLE;
      end
      FETCH:     state_nx_s = LOAD;
      LOAD:      state_nx_s = WAIT_DATA;
      WAIT_DATA: begin
        if (!blk_empty) state_nx_s = START;
        else            state_nx_s = WAIT_DATA;
      end
      START:     state_nx_s = ENCODE;
      ENCODE: begin
        // A done arriving on the last watchdog cycle still completes the block.
        if (enc_done)                 state_nx_s = DRAIN;
        else if (wdog_r == WDOG_LAST) state_nx_s = ERR;
        else                          state_nx_s = ENCODE;
      end
      DRAIN: begin
        if (last_s) state_nx_s = DONE;
        else        state_nx_s = DRAIN;
      end
      DONE:      state_nx_s = IDLE;
      ERR:       state_nx_s = ERR;
      default:   state_nx_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_nx_s;
  end

  // Encode-phase watchdog, cleared on the start pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      wdog_r <= '0;
    end else if (state_r == START) begin
      wdog_r <= '0;
    end else if (state_r == ENCODE) begin
      wdog_r <= wdog_r + CNT_W'(1);
    end
  end

  // Metadata latch; the FIFO q is valid the cycle after the read request
  always_ff @(posedge clk) begin
    if (reset) begin
      tail_r   <= 8'd0;
      size_r   <= 1'b0;
      target_r <= '0;
    end else if (state_r == LOAD) begin
      tail_r   <= meta_tail;
      size_r   <= meta_size;
      target_r <= size_to_bytes(meta_size);
    end
  end

  // Registered control/status outputs decoded from the upcoming state
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_rdreq_r <= 1'b0;
      blk_ready_r  <= 1'b0;
      busy_r       <= 1'b0;
      err_r        <= 1'b0;
      blk_cnt_r    <= 16'd0;
    end else begin
      meta_rdreq_r <= (state_nx_s == FETCH);
      blk_ready_r  <= (state_nx_s == START);
      busy_r       <= (state_nx_s != IDLE) && (state_nx_s != ERR);
      err_r        <= err_r || (state_nx_s == ERR);
      if (state_r == DONE) begin
        blk_cnt_r <= blk_cnt_r + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_conv_enc_ctrl.sv
// Scoreboard bench for conv_enc_ctrl: stimulus pushes expected triples per block,
// a negedge monitor pops and compares them and checks flow-control rules.
module tb_conv_enc_ctrl;

  typedef struct { logic size; logic [7:0] tail; } meta_t;
  typedef struct { logic size; logic last; } trip_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        meta_empty = 1'b1;
  logic        meta_size = 1'b0;
  logic [7:0]  meta_tail = 8'd0;
  logic        meta_rdreq;
  logic        blk_empty = 1'b1;
  logic        enc_blk_ready;
  logic [7:0]  enc_tail_byte;
  logic        enc_size;
  logic        enc_done = 1'b0;
  logic        enc_rdreq_subblock;
  logic        ds_ready = 1'b1;
  logic        out_valid;
  logic        out_last;
  logic        out_size;
  logic        busy;
  logic        err_timeout;
  logic [15:0] blk_count;

  conv_enc_ctrl dut (
    .clk(clk), .reset(reset), .meta_empty(meta_empty), .meta_size(meta_size),
    .meta_tail(meta_tail), .meta_rdreq(meta_rdreq), .blk_empty(blk_empty),
    .enc_blk_ready(enc_blk_ready), .enc_tail_byte(enc_tail_byte), .enc_size(enc_size),
    .enc_done(enc_done), .enc_rdreq_subblock(enc_rdreq_subblock), .ds_ready(ds_ready),
    .out_valid(out_valid), .out_last(out_last), .out_size(out_size), .busy(busy),
    .err_timeout(err_timeout), .blk_count(blk_count)
  );

  always #5 clk = ~clk;

  meta_t meta_q[$];
  meta_t start_q[$];
  trip_t exp_q[$];
  int    lastcyc_q[$];
  int    n_chk = 0;
  int    n_err = 0;
  int    nvalid = 0;
  int    n_last = 0;
  int    exp_blk = 0;
  int    cyc = 0;
  int    n_rd = 0;
  int    lv = 0;
  logic  prev_ready_pulse = 1'b0;
  logic  prev_meta_rd = 1'b0;
  logic  env_rd;
  meta_t env_m;
  meta_t mon_s;
  trip_t mon_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Show-ahead-off metadata FIFO model
  always @(posedge clk) begin
    env_rd = meta_rdreq;
    #1;
    if (env_rd && meta_q.size() > 0) begin
      env_m = meta_q.pop_front();
      meta_size = env_m.size;
      meta_tail = env_m.tail;
    end
    meta_empty = (meta_q.size() == 0);
  end

  // Monitor: scoreboard pops and protocol checks
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      n_rd = 0;
      lastcyc_q.delete();
      prev_ready_pulse = 1'b0;
      prev_meta_rd = 1'b0;
      lv = 0;
    end else begin
      if (out_valid) begin
        nvalid++;
        if (exp_q.size() == 0) begin
          chk("unexpected_triple", 32'd1, 32'd0);
        end else begin
          mon_t = exp_q.pop_front();
          chk("out_last", {31'd0, out_last}, {31'd0, mon_t.last});
          chk("out_size", {31'd0, out_size}, {31'd0, mon_t.size});
        end
        if (out_last) begin
          n_last++;
          lastcyc_q.push_back(cyc);
        end
      end else if (out_last) begin
        chk("last_without_valid", {31'd0, out_valid}, 32'd1);
      end
      if (!ds_ready) begin
        chk("rdreq_while_not_ready", {31'd0, enc_rdreq_subblock}, 32'd0);
        if (out_valid) begin
          lv++;
          chk("skid_depth", (lv <= 1) ? 32'd1 : 32'd0, 32'd1);
        end
      end else begin
        lv = 0;
      end
      if (enc_blk_ready) begin
        chk("start_pulse_width", {31'd0, prev_ready_pulse}, 32'd0);
        if (start_q.size() == 0) begin
          chk("unexpected_start", 32'd1, 32'd0);
        end else begin
          mon_s = start_q.pop_front();
          chk("enc_tail_byte", {24'd0, enc_tail_byte}, {24'd0, mon_s.tail});
          chk("enc_size", {31'd0, enc_size}, {31'd0, mon_s.size});
        end
      end
      if (meta_rdreq) begin
        chk("meta_rdreq_width", {31'd0, prev_meta_rd}, 32'd0);
        n_rd++;
        if (n_rd > 1) begin
          if (lastcyc_q.size() < n_rd - 1) chk("refetch_before_done", 32'd1, 32'd0);
          else chk("refetch_spacing", (cyc - lastcyc_q[n_rd-2] >= 2) ? 32'd1 : 32'd0, 32'd1);
        end
      end
      prev_ready_pulse = enc_blk_ready;
      prev_meta_rd = meta_rdreq;
    end
  end

  task automatic issue(input logic sz, input logic [7:0] tail);
    meta_t m;
    trip_t t;
    int n;
    m.size = sz;
    m.tail = tail;
    meta_q.push_back(m);
    start_q.push_back(m);
    n = sz ? 768 : 132;
    for (int i = 1; i <= n; i++) begin
      t.size = sz;
      t.last = (i == n);
      exp_q.push_back(t);
    end
  endtask

  // d<0 withholds enc_done; stop_at>0 abandons the drain after that many triples
  task automatic serve(input logic sz, input int d, input int mode, input int stop_at);
    int k;
    int nv0;
    int nl0;
    int n;
    n = sz ? 768 : 132;
    k = 0;
    while (!meta_rdreq && k < 300) begin step(); k++; end
    chk("fetch_seen", {31'd0, meta_rdreq}, 32'd1);
    repeat (4) step();
    blk_empty = 1'b0;
    k = 0;
    while (!enc_blk_ready && k < 50) begin step(); k++; end
    chk("start_seen", {31'd0, enc_blk_ready}, 32'd1);
    blk_empty = 1'b1;
    chk("busy_at_start", {31'd0, busy}, 32'd1);
    if (d < 0) return;
    nv0 = nvalid;
    nl0 = n_last;
    repeat (d) step();
    enc_done = 1'b1;
    step();
    enc_done = 1'b0;
    k = 0;
    while (n_last == nl0 && k < 5000) begin
      if (stop_at > 0 && (nvalid - nv0) >= stop_at) break;
      case (mode)
        0:       ds_ready = 1'b1;
        1:       ds_ready = ~ds_ready;
        default: ds_ready = 1'($urandom_range(0, 1));
      endcase
      step();
      k++;
    end
    ds_ready = 1'b1;
    if (stop_at > 0) return;
    chk("drain_finished", (k < 5000) ? 32'd1 : 32'd0, 32'd1);
    chk("valid_count", nvalid - nv0, n);
    step();
    exp_blk++;
    chk("blk_count", {16'd0, blk_count}, exp_blk);
    chk("err_stays_clear", {31'd0, err_timeout}, 32'd0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    meta_q.delete();
    start_q.delete();
    exp_q.delete();
    step();
    reset = 1'b0;
    exp_blk = 0;
  endtask

  task automatic check_idle_outputs(input string nm);
    chk(nm, {15'd0, meta_rdreq, enc_blk_ready, enc_tail_byte, enc_size, enc_rdreq_subblock,
             out_valid, out_last, out_size, busy, err_timeout}, 32'd0);
    chk({nm, "_blk"}, {16'd0, blk_count}, 32'd0);
  endtask

  initial begin
    int k;
    int nrd;
    repeat (3) step();
    reset = 1'b0;
    step();
    check_idle_outputs("reset_state");

    issue(1'b0, 8'hA5);
    serve(1'b0, 140, 0, 0);

    issue(1'b1, 8'($urandom));
    serve(1'b1, $urandom_range(1, 300), 1, 0);

    issue(1'b0, 8'($urandom));
    issue(1'b1, 8'($urandom));
    serve(1'b0, $urandom_range(1, 200), 0, 0);
    serve(1'b1, $urandom_range(1, 200), 2, 0);

    issue(1'b0, 8'($urandom));
    serve(1'b0, 2048, 0, 0);

    issue(1'b1, 8'($urandom));
    serve(1'b1, 20, 0, 50);
    pulse_reset();
    check_idle_outputs("after_mid_drain_reset");
    issue(1'b0, 8'($urandom));
    serve(1'b0, $urandom_range(1, 300), 2, 0);

    issue(1'b0, 8'h3C);
    serve(1'b0, -1, 0, 0);
    k = 0;
    while (!err_timeout && k < 3000) begin step(); k++; end
    chk("timeout_latency", k, 2049);
    chk("err_flag", {31'd0, err_timeout}, 32'd1);
    chk("busy_in_err", {31'd0, busy}, 32'd0);
    meta_q.push_back('{size: 1'b0, tail: 8'h11});
    nrd = 0;
    repeat (20) begin
      step();
      if (meta_rdreq) nrd++;
    end
    chk("no_fetch_in_err", nrd, 0);
    chk("err_sticky", {31'd0, err_timeout}, 32'd1);
    pulse_reset();
    check_idle_outputs("after_err_reset");

    for (int b = 0; b < 3; b++) begin
      logic sz;
      sz = 1'($urandom_range(0, 1));
      issue(sz, 8'($urandom));
      serve(sz, $urandom_range(1, 400), 2, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
